// File: rtl/vec3_alu_pipe_if.sv
// Handshake bundle for vec3_alu_pipe: input beat channel plus result channel.
// valid/ready: a beat moves on a rising edge where valid && ready; the holder keeps it stable until then.
interface vec3_alu_pipe_if #(
   parameter int W     = 32,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic             shift_a;
   logic [TAG_W-1:0] tag;
   logic [W-1:0]     ax, ay, az, bx, by, bz;
   logic             out_valid;
   logic             out_ready;
   logic             out_op;
   logic [TAG_W-1:0] out_tag;
   logic [W-1:0]     out_x, out_y, out_z;
   logic [2*W-1:0]   out_dot;
   logic             out_ovf;

   modport master (
      output in_valid, op, shift_a, tag, ax, ay, az, bx, by, bz, out_ready,
      input  in_ready, out_valid, out_op, out_tag, out_x, out_y, out_z, out_dot, out_ovf
   );

   modport slave (
      input  in_valid, op, shift_a, tag, ax, ay, az, bx, by, bz, out_ready,
      output in_ready, out_valid, out_op, out_tag, out_x, out_y, out_z, out_dot, out_ovf
   );
endinterface

// File: rtl/vec3_alu_pipe.sv
// Three-stage vec3 SUB / signed DOT ALU with tag pass-through and a global-advance stall.
// Define VEC3_ALU_SAT_EN to clamp the DOT sum to 2W bits and flag it on out_ovf; otherwise it wraps.
module vec3_alu_pipe #(
   parameter int W     = 32,
   parameter int SHIFT = 16,
   parameter int TAG_W = 8
) (
   input logic         clk,
   input logic         reset,
   vec3_alu_pipe_if.slave bus
);
   logic                    adv;
   logic signed [W-1:0]     a_in [3];
   logic signed [W-1:0]     b_in [3];
   logic signed [2*W-1:0]   prod [3];
   logic signed [2*W-1:0]   dot_c;
   logic                    ovf_c;

   logic                    s1_valid, s1_op;
   logic [TAG_W-1:0]        s1_tag;
   logic signed [W-1:0]     s1_a [3];
   logic signed [W-1:0]     s1_b [3];

   logic                    s2_valid, s2_op;
   logic [TAG_W-1:0]        s2_tag;
   logic signed [W-1:0]     s2_d [3];
   logic signed [2*W-1:0]   s2_p [3];

   logic                    s3_valid, s3_op, s3_ovf;
   logic [TAG_W-1:0]        s3_tag;
   logic signed [W-1:0]     s3_x, s3_y, s3_z;
   logic signed [2*W-1:0]   s3_dot;

   // Whole pipe moves or whole pipe holds; bubbles are never squeezed out.
   assign adv          = !s3_valid || bus.out_ready;
   assign bus.in_ready = adv;

   always_comb begin
      a_in[0] = bus.ax;
      a_in[1] = bus.ay;
      a_in[2] = bus.az;
      b_in[0] = bus.bx;
      b_in[1] = bus.by;
      b_in[2] = bus.bz;
      if (bus.shift_a) begin
         for (int i = 0; i < 3; i++) a_in[i] = a_in[i] <<< SHIFT;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) prod[i] = (2*W)'(s1_a[i]) * (2*W)'(s1_b[i]);
   end

`ifdef VEC3_ALU_SAT_EN
   logic signed [2*W+1:0] sum;

   // The sum fits in 2W bits only when its top three bits agree.
   always_comb begin
      sum   = (2*W+2)'(s2_p[0]) + (2*W+2)'(s2_p[1]) + (2*W+2)'(s2_p[2]);
      ovf_c = (sum[2*W+1:2*W-1] != 3'b000) && (sum[2*W+1:2*W-1] != 3'b111);
      if (ovf_c) dot_c = sum[2*W+1] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
      else       dot_c = sum[2*W-1:0];
   end
`else
   always_comb begin
      dot_c = s2_p[0] + s2_p[1] + s2_p[2];
      ovf_c = 1'b0;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= 1'b0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_op    <= 1'b0;
         s2_tag   <= '0;
         for (int i = 0; i < 3; i++) begin
            s1_a[i] <= '0;
            s1_b[i] <= '0;
            s2_d[i] <= '0;
            s2_p[i] <= '0;
         end
         s3_valid <= 1'b0;
         s3_op    <= 1'b0;
         s3_ovf   <= 1'b0;
         s3_tag   <= '0;
         s3_x     <= '0;
         s3_y     <= '0;
         s3_z     <= '0;
         s3_dot   <= '0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         s1_op    <= bus.op;
         s1_tag   <= bus.tag;
         for (int i = 0; i < 3; i++) begin
            s1_a[i] <= a_in[i];
            s1_b[i] <= b_in[i];
            s2_d[i] <= s1_a[i] - s1_b[i];
            s2_p[i] <= prod[i];
         end
         s2_valid <= s1_valid;
         s2_op    <= s1_op;
         s2_tag   <= s1_tag;
         s3_valid <= s2_valid;
         s3_op    <= s2_op;
         s3_tag   <= s2_tag;
         if (s2_op) begin
            s3_x   <= '0;
            s3_y   <= '0;
            s3_z   <= '0;
            s3_dot <= dot_c;
            s3_ovf <= ovf_c;
         end else begin
            s3_x   <= s2_d[0];
            s3_y   <= s2_d[1];
            s3_z   <= s2_d[2];
            s3_dot <= '0;
            s3_ovf <= 1'b0;
         end
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.out_op    = s3_op;
   assign bus.out_tag   = s3_tag;
   assign bus.out_x     = s3_x;
   assign bus.out_y     = s3_y;
   assign bus.out_z     = s3_z;
   assign bus.out_dot   = s3_dot;
   assign bus.out_ovf   = s3_ovf;
endmodule

// File: tb/tb_vec3_alu_pipe.sv
// Bench for vec3_alu_pipe: W=32 instance under a scoreboard, W=8 instance for DOT saturation.
module tb_vec3_alu_pipe;
   localparam int EXP_W = 170; // {op, tag[8], x[32], y[32], z[32], dot[64], ovf}

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rnd_ready = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_in = 0;
   int   n_out = 0;
   logic [EXP_W-1:0] exp_q[$];

   vec3_alu_pipe_if #(.W(32), .TAG_W(8)) bus ();
   vec3_alu_pipe_if #(.W(8),  .TAG_W(8)) bus8 ();

   vec3_alu_pipe #(.W(32), .SHIFT(16), .TAG_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   vec3_alu_pipe #(.W(8),  .SHIFT(4),  .TAG_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its end");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp_v);
      end
   endtask

   // Reference: plain 128-bit integer arithmetic on the operand values.
   function automatic logic [EXP_W-1:0] model(input logic op, input logic sh, input logic [7:0] tg,
                                              input logic [95:0] a, input logic [95:0] b);
      logic signed [127:0] ap, bp, s, mx, mn;
      logic [127:0] t;
      logic [31:0]  d [3];
      logic [63:0]  dot;
      logic         ovf;
      mx = (128'sd1 <<< 63) - 128'sd1;
      mn = -(128'sd1 <<< 63);
      s = '0;
      dot = '0;
      ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ap = $signed(a[32*i +: 32]);
         if (sh) begin
            ap = ap * 65536;
            t = ap;
            ap = $signed(t[31:0]);
         end
         bp = $signed(b[32*i +: 32]);
         d[i] = op ? 32'd0 : 32'(ap - bp);
         s = s + ap * bp;
      end
      if (op) begin
`ifdef VEC3_ALU_SAT_EN
         if (s > mx) begin
            dot = mx[63:0];
            ovf = 1'b1;
         end else if (s < mn) begin
            dot = mn[63:0];
            ovf = 1'b1;
         end else begin
            dot = s[63:0];
         end
`else
         dot = s[63:0];
`endif
      end
      return {op, tg, d[0], d[1], d[2], dot, ovf};
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (reset) begin
         exp_q.delete();
      end else begin
         check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.op, bus.shift_a, bus.tag,
                                  {bus.az, bus.ay, bus.ax}, {bus.bz, bus.by, bus.bx}));
            n_in++;
         end
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_op",  bus.out_op,  e[169]);
               check("out_tag", bus.out_tag, e[168:161]);
               check("out_x",   bus.out_x,   e[160:129]);
               check("out_y",   bus.out_y,   e[128:97]);
               check("out_z",   bus.out_z,   e[96:65]);
               check("out_dot", bus.out_dot, e[64:1]);
               check("out_ovf", bus.out_ovf, e[0]);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic op, input logic sh, input logic [7:0] tg,
                       input logic [95:0] a, input logic [95:0] b);
      logic acc;
      acc = 1'b0;
      bus.op = op;
      bus.shift_a = sh;
      bus.tag = tg;
      {bus.az, bus.ay, bus.ax} = a;
      {bus.bz, bus.by, bus.bx} = b;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         acc = bus.in_ready;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("accepted", acc, 1'b1);
   endtask

   task automatic drain();
      rnd_ready = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_valid"}, bus.out_valid, 1'b0);
      check({name, "_op"},    bus.out_op,    1'b0);
      check({name, "_tag"},   bus.out_tag,   8'h00);
      check({name, "_xyz"},   {bus.out_x, bus.out_y, bus.out_z}, 96'h0);
      check({name, "_dot"},   bus.out_dot,   64'h0);
      check({name, "_ovf"},   bus.out_ovf,   1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [95:0] a, b;
      logic        op;
      bus.in_valid = 1'b0; bus.op = 1'b0; bus.shift_a = 1'b0; bus.tag = '0;
      {bus.ax, bus.ay, bus.az, bus.bx, bus.by, bus.bz} = '0;
      bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.op = 1'b0; bus8.shift_a = 1'b0; bus8.tag = '0;
      {bus8.ax, bus8.ay, bus8.az, bus8.bx, bus8.by, bus8.bz} = '0;
      bus8.out_ready = 1'b1;

      // reset values
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      check("reset_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;

      // SUB with promotion: 3<<16 - 0x10000, result after the third edge counting the accept edge
      send(1'b0, 1'b1, 8'h5A, {32'd0, 32'd0, 32'h3}, {32'd0, 32'd0, 32'h0001_0000});
      @(negedge clk); check("lat_s1", bus.out_valid, 1'b0);
      @(negedge clk); check("lat_s2", bus.out_valid, 1'b0);
      @(negedge clk); check("lat_s3", bus.out_valid, 1'b1);
      check("promo_x",   bus.out_x,   32'h0002_0000);
      check("promo_tag", bus.out_tag, 8'h5A);
      check("promo_dot", bus.out_dot, 64'h0);

      // DOT with mixed signs: 10 - 18 - 4 = -12
      send(1'b1, 1'b0, 8'h11, {32'd4, -32'sd3, 32'd2}, {-32'sd1, 32'd6, 32'd5});
      repeat (3) @(negedge clk);
      check("dot_valid", bus.out_valid, 1'b1);
      check("dot_val",   bus.out_dot,   64'hFFFF_FFFF_FFFF_FFF4);
      check("dot_xyz",   {bus.out_x, bus.out_y, bus.out_z}, 96'h0);
      check("dot_ovf",   bus.out_ovf,   1'b0);
      @(negedge clk);
      drain();

      // random stream with random backpressure, alternating ops, incrementing tags
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = i[0];
         a = {$urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom};
         if (i % 7 == 3) begin
            op = 1'b1;
            a = {3{32'h8000_0000}};
            b = {3{32'h8000_0000}};
         end else if (i % 5 == 2) begin
            a = {3{32'h7FFF_FFFF}};
            b = {3{32'h7FFF_FFFF}};
         end
         send(op, 1'($urandom_range(0, 1)), 8'(8'h20 + i), a, b);
      end
      @(negedge clk);
      drain();
      check("in_out_count", n_out, n_in);

      // reset mid-flight: three beats in, reset before any emerges
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.op = 1'b0; bus.shift_a = 1'b0; bus.ax = 32'd9; bus.bx = 32'd1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.tag = 8'(8'h70 + i);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_zero_outputs("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_idle", bus.out_valid, 1'b0);
      end

      // empty-pipe acceptance with out_ready held low from reset
      bus.out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.op = 1'b0; bus.shift_a = 1'b0; bus.ax = 32'd100; bus.bx = 32'd1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.tag = 8'(8'hA0 + i);
         @(negedge clk);
         check("empty_in_ready", bus.in_ready, 1'b1);
         @(posedge clk); #1;
      end
      bus.tag = 8'hA3;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stall_in_ready", bus.in_ready, 1'b0);
         check("stall_valid",    bus.out_valid, 1'b1);
         check("stall_tag",      bus.out_tag,  8'hA0);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      drain();

      // saturation on the W=8 instance: three products of 16384
      @(posedge clk); #1;
      bus8.op = 1'b1; bus8.tag = 8'h33;
      {bus8.ax, bus8.ay, bus8.az, bus8.bx, bus8.by, bus8.bz} = {6{8'h80}};
      bus8.in_valid = 1'b1;
      @(negedge clk);
      check("sat_in_ready", bus8.in_ready, 1'b1);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sat_valid", bus8.out_valid, 1'b1);
      check("sat_tag",   bus8.out_tag,   8'h33);
      check("sat_xyz",   {bus8.out_x, bus8.out_y, bus8.out_z}, 24'h0);
`ifdef VEC3_ALU_SAT_EN
      check("sat_dot", bus8.out_dot, 16'h7FFF);
      check("sat_ovf", bus8.out_ovf, 1'b1);
`else
      check("sat_dot", bus8.out_dot, 16'hC000);
      check("sat_ovf", bus8.out_ovf, 1'b0);
`endif

      // final report
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
